// File: rtl/pixel_window_3x3.sv
// -----------------------------------------------------------------------------
// pixel_window_3x3
//
// Streaming 3x3 neighbourhood builder. Accepts one raster-order pixel per
// enabled cycle, together with the column/row it came from. Two line buffers
// hold the previous two image rows, and a 3x3 shift register assembles the
// window. A window is emitted for every interior position (x>=2, y>=2). The
// window is centred on (x-1, y-1).
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous reset, ACTIVE-HIGH (the existing codebase name
//               is kept even though the polarity is high)
//   en          pixel valid; pix_in/x_in/y_in are taken when en=1
//   sclr        synchronous clear; has priority over en
//   img_dim     image side, 3..256 (square image)
//   pix_in      pixel from the image RAM
//   x_in, y_in  column/row of pix_in
//   win_valid   one-cycle strobe: win/win_x/win_y hold a valid window
//   win         9 pixels, row-major; [PIX_W-1:0] is top-left and
//               [9*PIX_W-1:8*PIX_W] is bottom-right
//   win_x/y     window centre coordinates
//   win_sum     (PIXWIN_SUM_EN only) unsigned sum of the nine pixels
//   frame_done  one-cycle pulse with the last window of the frame
//
// Configuration
//   PIXWIN_SUM_EN  when defined, adds win_sum and one register stage. All
//                  outputs then have latency 2 and stay aligned with win_sum.
// -----------------------------------------------------------------------------
module pixel_window_3x3 #(
    parameter int PIX_W   = 8,
    parameter int MAX_DIM = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sclr,
    input  logic [8:0]         img_dim,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic [7:0]         x_in,
    input  logic [7:0]         y_in,
    output logic               win_valid,
    output logic [9*PIX_W-1:0] win,
    output logic [7:0]         win_x,
    output logic [7:0]         win_y,
`ifdef PIXWIN_SUM_EN
    output logic [PIX_W+3:0]   win_sum,
`endif
    output logic               frame_done
);

    localparam int AW = $clog2(MAX_DIM);

    logic [PIX_W-1:0]   lb_a [MAX_DIM];   // row y-1
    logic [PIX_W-1:0]   lb_b [MAX_DIM];   // row y-2
    logic [AW-1:0]      addr;
    logic               accept;
    logic               dim_ok;
    logic               is_last;
    logic [9*PIX_W-1:0] win_next;

    // Stage-1 registers: the window as of the latest accepted pixel.
    logic               s1_valid;
    logic               s1_done;
    logic [9*PIX_W-1:0] s1_win;
    logic [7:0]         s1_x;
    logic [7:0]         s1_y;

    assign addr    = x_in[AW-1:0];
    assign accept  = en && !sclr;
    assign dim_ok  = (img_dim >= 9'd3) && (img_dim <= 9'd256);
    assign is_last = ({1'b0, x_in} == img_dim - 9'd1) &&
                     ({1'b0, y_in} == img_dim - 9'd1);

    // NOTE: the line buffers have no reset. Clearing a RAM would prevent
    // block-RAM inference, and their contents are never observed before rows
    // 0 and 1 of a frame have rewritten them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_b[addr] <= lb_a[addr];
            lb_a[addr] <= pix_in;
        end
    end

    // The window shifts one column left. The new right column is
    // {row y-2, row y-1, current pixel}, from top to bottom.
    always_comb begin
        // NOTE: the default assignment comes first so that every path drives
        // every bit; otherwise a latch would be inferred.
        win_next = s1_win;
        for (int r = 0; r < 3; r++) begin
            win_next[(3*r)*PIX_W   +: PIX_W] = s1_win[(3*r+1)*PIX_W +: PIX_W];
            win_next[(3*r+1)*PIX_W +: PIX_W] = s1_win[(3*r+2)*PIX_W +: PIX_W];
        end
        win_next[2*PIX_W +: PIX_W] = lb_b[addr];
        win_next[5*PIX_W +: PIX_W] = lb_a[addr];
        win_next[8*PIX_W +: PIX_W] = pix_in;
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1_valid <= 1'b0;
            s1_done  <= 1'b0;
            s1_win   <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (sclr) begin
            s1_valid <= 1'b0;
            s1_done  <= 1'b0;
            s1_win   <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (en) begin
            // Columns 0/1 are gated, so stale columns from the previous row
            // never appear in a valid window.
            s1_valid <= dim_ok && (x_in >= 8'd2) && (y_in >= 8'd2);
            s1_done  <= dim_ok && is_last;
            s1_win   <= win_next;
            s1_x     <= x_in - 8'd1;
            s1_y     <= y_in - 8'd1;
        end else begin
            s1_valid <= 1'b0;
            s1_done  <= 1'b0;
        end
    end

`ifdef PIXWIN_SUM_EN
    logic [PIX_W+3:0] sum_next;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < 9; i++) begin
            sum_next = sum_next + {4'b0000, s1_win[i*PIX_W +: PIX_W]};
        end
    end

    // The second stage copies stage 1 every cycle. It holds whenever
    // stage 1 holds, and it is cleared together with stage 1.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win        <= '0;
            win_x      <= '0;
            win_y      <= '0;
            win_sum    <= '0;
        end else if (sclr) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win        <= '0;
            win_x      <= '0;
            win_y      <= '0;
            win_sum    <= '0;
        end else begin
            win_valid  <= s1_valid;
            frame_done <= s1_done;
            win        <= s1_win;
            win_x      <= s1_x;
            win_y      <= s1_y;
            win_sum    <= sum_next;
        end
    end
`else
    assign win_valid  = s1_valid;
    assign frame_done = s1_done;
    assign win        = s1_win;
    assign win_x      = s1_x;
    assign win_y      = s1_y;
`endif

endmodule

// File: tb/tb_pixel_window_3x3.sv
module tb_pixel_window_3x3;

`ifdef PIXWIN_SUM_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sclr;
    logic [8:0]  img_dim;
    logic [7:0]  pix_in;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic        win_valid;
    logic [71:0] win;
    logic [7:0]  win_x;
    logic [7:0]  win_y;
    logic        frame_done;
`ifdef PIXWIN_SUM_EN
    logic [11:0] win_sum;
`endif

    always #5 clk = ~clk;

    pixel_window_3x3 #(.PIX_W(8), .MAX_DIM(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sclr       (sclr),
        .img_dim    (img_dim),
        .pix_in     (pix_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .win_valid  (win_valid),
        .win        (win),
        .win_x      (win_x),
        .win_y      (win_y),
`ifdef PIXWIN_SUM_EN
        .win_sum    (win_sum),
`endif
        .frame_done (frame_done)
    );

    // Reference model: the frame is held as a 2-D image, and each window is
    // read straight from it by coordinates.
    typedef struct packed {
        logic        valid;
        logic        done;
        logic [71:0] w;
        logic [7:0]  x;
        logic [7:0]  y;
    } rec_t;

    rec_t        s1;
    logic [7:0]  img [256][256];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_valid, n_done, done_x, done_y, first_x, first_y;
    bit          have_first;
    logic [71:0] first_win;
    logic [71:0] ref_q[$];
    logic [71:0] cur_q[$];
    logic [11:0] last_sum;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] sum9(input logic [71:0] w);
        int s = 0;
        for (int i = 0; i < 9; i++) s += int'(w[i*8 +: 8]);
        return 12'(s);
    endfunction

    function automatic logic [7:0] pix_of(input int pat, input int x, input int y, input int dim);
        case (pat)
            0:       return 8'(16*y + x);
            1:       return 8'(y*dim + x + 1);
            2:       return 8'(x ^ y);
            default: return 8'hFF;
        endcase
    endfunction

    // One clock: drive the inputs, update the model at the edge, and compare
    // on the following falling edge.
    task automatic cycle(input bit e, input bit c, input int x, input int y,
                         input logic [7:0] p, input int dim);
        rec_t old_s1, ex;
        en = e; sclr = c; x_in = 8'(x); y_in = 8'(y); pix_in = p; img_dim = 9'(dim);
        @(posedge clk);
        old_s1 = s1;
        if (c) begin
            s1 = '0;
            ex = '0;
        end else begin
            if (e) begin
                img[y][x] = p;
                s1.valid  = (x >= 2) && (y >= 2);
                s1.done   = (x == dim-1) && (y == dim-1);
                s1.x      = 8'(x - 1);
                s1.y      = 8'(y - 1);
                if (s1.valid)
                    for (int r = 0; r < 3; r++)
                        for (int k = 0; k < 3; k++)
                            s1.w[(3*r+k)*8 +: 8] = img[y-2+r][x-2+k];
            end else begin
                s1.valid = 1'b0;
                s1.done  = 1'b0;
            end
            ex = (LAT == 1) ? s1 : old_s1;
        end
        @(negedge clk);
        check("win_valid", win_valid, ex.valid);
        check("frame_done", frame_done, ex.done);
        if (ex.valid) begin
            check("win", win, ex.w);
            check("win_x", win_x, ex.x);
            check("win_y", win_y, ex.y);
`ifdef PIXWIN_SUM_EN
            check("win_sum", win_sum, sum9(ex.w));
`endif
        end
        if (c) begin
            check("sclr_win", win, '0);
            check("sclr_x", win_x, '0);
            check("sclr_y", win_y, '0);
        end
        if (win_valid === 1'b1) begin
            n_valid++;
            cur_q.push_back(win);
`ifdef PIXWIN_SUM_EN
            last_sum = win_sum;
`endif
            if (!have_first) begin
                first_win = win; first_x = win_x; first_y = win_y; have_first = 1;
            end
        end
        if (frame_done === 1'b1) begin
            n_done++; done_x = win_x; done_y = win_y;
        end
    endtask

    // Sends a whole frame. If gaps is set, random idle cycles are inserted.
    // If (stop_x, stop_y) is reached, that pixel is sent with sclr and the
    // frame ends there.
    task automatic run_frame(input int dim, input int pat, input bit gaps,
                             input int stop_x, input int stop_y);
        n_valid = 0; n_done = 0; have_first = 0; cur_q.delete();
        for (int y = 0; y < dim; y++) begin
            for (int x = 0; x < dim; x++) begin
                if (gaps)
                    repeat ($urandom_range(0, 2))
                        cycle(1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255),
                              8'($urandom_range(0, 255)), dim);
                if (x == stop_x && y == stop_y) begin
                    cycle(1'b1, 1'b1, x, y, pix_of(pat, x, y, dim), dim);
                    return;
                end
                cycle(1'b1, 1'b0, x, y, pix_of(pat, x, y, dim), dim);
            end
        end
        cycle(1'b0, 1'b0, 0, 0, 8'h00, dim);
        cycle(1'b0, 1'b0, 0, 0, 8'h00, dim);
    endtask

    task automatic compare_to_ramp(input string tag);
        check({tag, "_len"}, cur_q.size(), ref_q.size());
        for (int i = 0; i < cur_q.size() && i < ref_q.size(); i++)
            check(tag, cur_q[i], ref_q[i]);
    endtask

    logic [71:0] fw;

    initial begin
        rst_n = 1'b1; en = 1'b0; sclr = 1'b0; img_dim = 9'd16;
        pix_in = '0; x_in = '0; y_in = '0; s1 = '0;
        #12;
        check("rst_valid", win_valid, '0);
        check("rst_done", frame_done, '0);
        check("rst_win", win, '0);
        check("rst_x", win_x, '0);
        check("rst_y", win_y, '0);
`ifdef PIXWIN_SUM_EN
        check("rst_sum", win_sum, '0);
`endif
        @(negedge clk);
        rst_n = 1'b0;

        // Ramp frame, 16x16, en held high.
        run_frame(16, 0, 1'b0, -1, -1);
        check("ramp_count", n_valid, 196);
        check("ramp_done_cnt", n_done, 1);
        check("ramp_done_x", done_x, 14);
        check("ramp_done_y", done_y, 14);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                fw[(3*r+k)*8 +: 8] = 8'(16*r + k);
        check("ramp_first_win", first_win, fw);
        check("ramp_first_x", first_x, 1);
        check("ramp_first_y", first_y, 1);
        ref_q = cur_q;

        // Minimum size, 3x3, pixels 1..9.
        run_frame(3, 1, 1'b0, -1, -1);
        check("min_count", n_valid, 1);
        check("min_done_cnt", n_done, 1);
        for (int i = 0; i < 9; i++) fw[i*8 +: 8] = 8'(i + 1);
        check("min_win", first_win, fw);
        check("min_x", first_x, 1);
        check("min_y", first_y, 1);
        check("min_done_x", done_x, 1);

        // Ramp with gaps in en: the window sequence must equal the gap-free run.
        run_frame(16, 0, 1'b1, -1, -1);
        check("gap_count", n_valid, 196);
        compare_to_ramp("gap_seq");

        // sclr together with en at (5,7), then a fresh frame.
        run_frame(16, 0, 1'b0, 5, 7);
        check("sclr_valid", win_valid, '0);
        check("sclr_done", frame_done, '0);
        run_frame(16, 0, 1'b0, -1, -1);
        check("post_sclr_count", n_valid, 196);
        compare_to_ramp("post_sclr_seq");

        // Asynchronous reset between edges, in the middle of a frame.
        n_valid = 0;
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 16; x++)
                if (y < 9 || x <= 8) cycle(1'b1, 1'b0, x, y, pix_of(0, x, y, 16), 16);
        #2 rst_n = 1'b1;
        #1;
        check("arst_valid", win_valid, '0);
        check("arst_done", frame_done, '0);
        check("arst_win", win, '0);
        check("arst_x", win_x, '0);
        check("arst_y", win_y, '0);
        s1 = '0;
        @(negedge clk);
        rst_n = 1'b0;
        run_frame(16, 0, 1'b0, -1, -1);
        check("post_rst_count", n_valid, 196);
        compare_to_ramp("post_rst_seq");

        // Maximum size, 256x256, pix = x ^ y.
        run_frame(256, 2, 1'b0, -1, -1);
        check("max_count", n_valid, 64516);
        check("max_done_cnt", n_done, 1);
        check("max_done_x", done_x, 254);
        check("max_done_y", done_y, 254);

`ifdef PIXWIN_SUM_EN
        // All-255 frame: every window sums to 9*255.
        run_frame(6, 3, 1'b0, -1, -1);
        check("sat_count", n_valid, 16);
        check("sat_sum", last_sum, 12'd2295);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_window_3x3.md
# pixel_window_3x3

Streaming 3x3 neighbourhood builder that sits directly downstream of `addr_gen` and the image RAM. It accepts one raster-order pixel per enabled cycle, tagged with the `x_cnt`/`y_cnt` coordinates that generated its read address. It keeps the two previous image rows in internal line buffers and emits a full 3x3 window for every interior pixel position, feeding the convolution stage.

## Interface
- `PIX_W`, 8, pixel width in bits
- `MAX_DIM`, 256, maximum image side; sets the line buffer depth
- `clk`  input  1  clock; all state changes on the rising edge
- `rst_n`  input  1  reset, asynchronous, active-high
- `en`  input  1  pixel valid; `pix_in`/`x_in`/`y_in` are accepted on a rising edge where `en`=1
- `sclr`  input  1  synchronous clear
- `img_dim`  input  9  image side in pixels, 3..256, square image
- `pix_in`  input  PIX_W  pixel read from image RAM
- `x_in`, `y_in`  input  8 each  column and row of `pix_in`, already aligned with RAM latency upstream
- `win_valid`  output  1  window on `win` is valid for one cycle
- `win`  output  9*PIX_W  window, row-major; [PIX_W-1:0] is top-left, top row first, [9*PIX_W-1:8*PIX_W] is bottom-right
- `win_x`, `win_y`  output  8 each  coordinates of the window centre
- `frame_done`  output  1  one-cycle pulse on the last pixel of the frame

## Operation
- State is held in two line buffers `lb_a` and `lb_b`, each MAX_DIM x PIX_W. `lb_a[x]` holds row y-1 and `lb_b[x]` holds row y-2.
- A 3x3 shift register holds the window.
- On an accepted pixel at (x,y), all of the following happen on the same edge:
  - The column {`lb_b[x]`, `lb_a[x]`, `pix_in`} (top to bottom) shifts into the right column of the window. The old right and middle columns move left, and the left column is dropped.
  - `lb_b[x]` <= old `lb_a[x]`, and `lb_a[x]` <= `pix_in`. Both line buffers are read before they are written.
  - `win_valid` <= (x>=2 && y>=2).
  - `win_x` <= x-1 and `win_y` <= y-1.
  - `frame_done` <= (x==img_dim-1 && y==img_dim-1).
- On an edge with no accepted pixel, `win_valid` and `frame_done` go to 0. The window, `win_x` and `win_y` hold their values.
- Border pixels (x<2 or y<2) update state but never produce a window. Only (img_dim-2)^2 windows are emitted per frame.
- Window contents are rows y-2..y and columns x-2..x. There is no padding.
- Row wrap: stale columns left in the window from the previous row are flushed because x=0 and x=1 are gated off by the x>=2 condition.
- `img_dim` is held constant for the whole frame. Out-of-range values (<3 or >256) produce no windows and no defined `frame_done`.
- `sclr`:
  - Clears the window registers, `win_valid`, `frame_done`, `win_x` and `win_y` to 0.
  - The line buffers are not cleared. They are don't-care because rows 0 and 1 are gated.
  - `sclr` has priority over `en`: a pixel presented together with `sclr` is discarded.
- Reset (`rst_n`=1): same clearing as `sclr`, applied asynchronously. Reset mid-frame discards the frame; the next frame must restart at (0,0).

## Timing
- Latency is 1 cycle. A pixel accepted at edge N yields `win_valid`=1 during cycle N..N+1 when its position qualifies.
- Throughput is one window per cycle. Back-to-back `en` is fully supported, and gaps in `en` are tolerated at any point.
- `frame_done` is coincident with the final `win_valid` of the frame (centre (img_dim-2, img_dim-2)).
- Reset value of every output is 0.

## Configuration
- `PIXWIN_SUM_EN` defined:
  - Adds output port `win_sum` (PIX_W+4 bits), the unsigned sum of the nine window pixels.
  - One pipeline stage is added. `win_valid`, `win`, `win_x`, `win_y` and `frame_done` are all delayed to latency 2 so that they stay aligned with `win_sum`.
  - `win_sum` resets to 0.
- Undefined: there is no `win_sum` port, no adder tree, and latency is 1.

## Test plan
- Ramp image, `img_dim`=16, `en` held high, pix = 16*y+x (mod 256). The bench must see:
  - exactly 196 `win_valid` pulses;
  - first window `win_x`=1, `win_y`=1, contents {0,1,2,16,17,18,32,33,34};
  - `frame_done` pulsed once, with the window centred at (14,14).
- Minimum size, `img_dim`=3, pixels 1..9 -> exactly one window {1..9}, centre (1,1), with `frame_done` in the same cycle.
- Maximum size, `img_dim`=256, pix = x ^ y -> the window at centre (254,254) equals the bench reference model, which checks that x=255 is addressed correctly with no wrap error. 64516 windows.
- Randomly gap `en` (about 50% duty) on a 16x16 frame -> window sequence identical to the gap-free run, and no `win_valid` is asserted on idle cycles.
- `sclr` asserted mid-frame at (5,7) together with `en` -> the pixel is dropped, and all outputs read 0 on the next cycle. A fresh frame from (0,0) then reproduces the ramp results.
- Assert `rst_n` mid-frame between edges -> outputs go to 0 immediately, without waiting for a clock edge. With `PIXWIN_SUM_EN` defined, a frame of all-255 pixels gives `win_sum`=2295 for every window at latency 2.
